div_iter: RTL and testbench
===========================

# div_iter

Parametrised iterative radix-2 integer divider for the EX stage. It computes quotient and remainder of a WIDTH-bit signed or unsigned division, one quotient bit per cycle. Operands are accepted on a valid/ready handshake and results are returned on a valid/ready handshake. It supports pipeline flush, defined divide-by-zero results and back-to-back operation, and can optionally skip the dividend's leading zeros to shorten latency.

## Interface
- WIDTH, 32, operand/result width; legal values are WIDTH ≥ 2
- clk  in  1  clock; every register samples on the rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of any in-flight or pending operation
- in_valid  in  1  operands are valid
- in_ready  out  1  divider can accept operands
- a  in  WIDTH  dividend
- b  in  WIDTH  divisor
- sign  in  1  1 = signed (two's complement), 0 = unsigned
- out_valid  out  1  result is valid
- out_ready  in  1  consumer takes the result
- quot  out  WIDTH  quotient
- rem  out  WIDTH  remainder
- div_by_zero  out  1  the current result came from b == 0

## Operation
- FSM states are IDLE, CALC and DONE.
- **Reset:**
  - Reset is asynchronous, one clock, active-low.
  - While rst_n is low: state = IDLE, in_ready = 0, out_valid = 0, quot = 0, rem = 0, div_by_zero = 0, and all internal registers are 0.
- **Handshakes:**
  - in_ready = !flush & (IDLE | (DONE & out_ready)).
  - An operand is accepted at an edge where in_valid & in_ready is high.
  - A result is consumed at an edge where out_valid & out_ready is high.
  - An operand accepted in DONE at the same edge its result is consumed gives back-to-back operation.
- **On accept:**
  - Latch a, b and sign.
  - Form |a| and |b|. An operand is negated only when sign=1 and its MSB=1. |b| is held in WIDTH+1 bits.
  - Load the shift register {rem_part, quot_part} with |a| pre-shifted.
  - Load the iteration counter with WIDTH.
- **Divide by zero (b == 0):** skip CALC and enter DONE at the next edge with quot = all ones, rem = a (raw, not negated) and div_by_zero = 1.
- **CALC, each edge:**
  - Compute trial = rem_part − |b| at WIDTH+1 bits.
  - If trial is non-negative, rem_part = trial and quotient bit = 1. Otherwise rem_part is kept and quotient bit = 0.
  - Shift the register and decrement the counter.
- **Final step:** the edge after the last iteration applies sign correction, registers quot and rem, and moves to DONE.
  - quot is negated when sign & (a[W-1] ^ b[W-1]).
  - rem is negated when sign & a[W-1], so the remainder takes the dividend's sign.
- **Signed overflow:** MIN / −1 needs no special case and gives quot = MIN, rem = 0.
- **DONE:**
  - out_valid = 1; quot, rem and div_by_zero are held stable until consumed.
  - On consume, go to IDLE, or to CALC if a new operand is accepted at the same edge.
- **flush:**
  - flush outranks everything except reset.
  - At the flush edge the FSM goes to IDLE, out_valid goes to 0 and the pending result is discarded.
  - in_ready is 0 while flush is high, so in_valid coinciding with flush is not accepted.

## Timing
- Accepting edge = E0. CALC iterates on edges E1..E_WIDTH. out_valid rises after edge E_(WIDTH+1), so latency is WIDTH+1 cycles.
- Divide-by-zero latency is 1 cycle: out_valid rises after E1.
- With back-to-back operation the throughput is one result per WIDTH+2 cycles.
- flush high during any cycle from E0 onward prevents out_valid from ever rising for that operation.
- in_ready is high in the cycle after the flush edge, provided flush has deasserted.

## Configuration
- **DIV_SKIP_LZ_EN defined:**
  - On accept, a leading-zero count lz of |a| sets the pre-shift and the iteration count WIDTH − lz, with a minimum of 1.
  - |a| = 0 runs 1 iteration.
  - Latency = WIDTH − lz + 1; results are identical to the non-skip build.
- **DIV_SKIP_LZ_EN undefined:** fixed WIDTH iterations, latency WIDTH+1, and no leading-zero logic is present.

## Structure
- **Shared package div_pkg:**
  - state enum {IDLE, CALC, DONE}.
  - CNT_W function/constant ($clog2(WIDTH+1)).
  - Divide-by-zero quotient constant (all ones).
- **Sub-module div_lzc:** parametrised leading-zero counter (WIDTH in, CNT_W out), instantiated only under DIV_SKIP_LZ_EN.

## Test plan
All scenarios use WIDTH=32.
- **Unsigned, macro off:** 100 / 7, sign=0 → quot=14, rem=2; out_valid exactly 33 edges after accept, in_ready low throughout.
- **Signed:**
  - −7 / 2 → quot=0xFFFFFFFD, rem=0xFFFFFFFF.
  - 7 / −2 → quot=0xFFFFFFFD, rem=1.
  - 0x80000000 / 0xFFFFFFFF → quot=0x80000000, rem=0.
- **Divide by zero:** a=0x1234, b=0 → quot=0xFFFFFFFF, rem=0x1234, div_by_zero=1; out_valid after 1 edge.
- **Backpressure and back-to-back:**
  - Hold out_ready=0 for 10 cycles in DONE → outputs stable.
  - Then raise out_ready together with in_valid (9 / 3) → both handshakes complete at the same edge; next result quot=3, rem=0.
- **Abort:**
  - flush at iteration 5 → out_valid never rises, in_ready=1 the next cycle, and a following 50 / 5 gives quot=10, rem=0.
  - rst_n low mid-CALC → outputs 0 immediately, without waiting for a clock edge.
- **Leading-zero skip (DIV_SKIP_LZ_EN):** 3 / 1 → quot=3, rem=0 with latency 3; 0 / 5 → quot=0, rem=0 with latency 2.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative radix-2 divider.
package div_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Replicated to WIDTH bits to form the all-ones divide-by-zero quotient.
  localparam logic DBZ_QUOT_BIT = 1'b1;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// Operand/result handshake bundle between the EX stage and the divider.
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sign;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             div_by_zero;

  modport master (
    output in_valid, a, b, sign, out_ready,
    input  in_ready, out_valid, quot, rem, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, sign, out_ready,
    output in_ready, out_valid, quot, rem, div_by_zero
  );
endinterface

// File: rtl/div_lzc.sv
// Parametrised leading-zero counter; an all-zero input returns WIDTH.
module div_lzc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic [WIDTH-1:0] val_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic found_s;

  // Scan from the MSB and stop counting at the first set bit
  always_comb begin
    cnt_o   = CNT_W'(WIDTH);
    found_s = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found_s && val_i[i]) begin
        cnt_o   = CNT_W'(WIDTH - 1 - i);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, signed/unsigned, one quotient bit per cycle.
// Optional leading-zero skip of the dividend is enabled by defining DIV_SKIP_LZ_EN.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  div_iter_if.slave bus
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH:0]   babs_q, babs_d;
  logic             sign_q, sign_d;
  logic             bmsb_q, bmsb_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] rem_part_q, rem_part_d;
  logic [WIDTH-1:0] quot_part_q, quot_part_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic             accept_s;
  logic             consume_s;
  logic [WIDTH-1:0] aabs_s;
  logic [WIDTH-1:0] babs_in_s;
  logic [WIDTH-1:0] aload_s;
  logic [CNT_W-1:0] cnt_load_s;
  logic [WIDTH:0]   partial_s;
  logic [WIDTH:0]   trial_s;

  assign bus.in_ready = rst_n & ~flush &
                        ((state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready));
  assign accept_s     = bus.in_valid & bus.in_ready;
  assign consume_s    = bus.out_valid & bus.out_ready;

  assign aabs_s    = (bus.sign & bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign babs_in_s = (bus.sign & bus.b[WIDTH-1]) ? -bus.b : bus.b;

`ifdef DIV_SKIP_LZ_EN
  logic [CNT_W-1:0] lz_s;

  div_lzc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lzc (
    .val_i (aabs_s),
    .cnt_o (lz_s)
  );

  // Zero dividend still runs one iteration so the FSM path is unchanged.
  assign aload_s    = aabs_s << lz_s;
  assign cnt_load_s = (lz_s == CNT_W'(WIDTH)) ? CNT_W'(1) : (CNT_W'(WIDTH) - lz_s);
`else
  assign aload_s    = aabs_s;
  assign cnt_load_s = CNT_W'(WIDTH);
`endif

  // The modular WIDTH+1-bit difference has MSB clear exactly when partial >= |b|.
  assign partial_s = {rem_part_q, quot_part_q[WIDTH-1]};
  assign trial_s   = partial_s - babs_q;

  assign bus.out_valid   = (state_q == ST_DONE);
  assign bus.quot        = quot_q;
  assign bus.rem         = rem_q;
  assign bus.div_by_zero = div_by_zero_q;

  // Next-state and datapath update
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    a_d           = a_q;
    babs_d        = babs_q;
    sign_d        = sign_q;
    bmsb_d        = bmsb_q;
    dbz_d         = dbz_q;
    rem_part_d    = rem_part_q;
    quot_part_d   = quot_part_q;
    quot_d        = quot_q;
    rem_d         = rem_q;
    div_by_zero_d = div_by_zero_q;

    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_CALC: begin
          if (dbz_q) begin
            quot_d        = {WIDTH{DBZ_QUOT_BIT}};
            rem_d         = a_q;
            div_by_zero_d = 1'b1;
            state_d       = ST_DONE;
          end else if (cnt_q != CNT_W'(0)) begin
            if (!trial_s[WIDTH]) begin
              rem_part_d  = trial_s[WIDTH-1:0];
              quot_part_d = {quot_part_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_part_d  = partial_s[WIDTH-1:0];
              quot_part_d = {quot_part_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            quot_d        = (sign_q & (a_q[WIDTH-1] ^ bmsb_q)) ? -quot_part_q : quot_part_q;
            rem_d         = (sign_q & a_q[WIDTH-1]) ? -rem_part_q : rem_part_q;
            div_by_zero_d = 1'b0;
            state_d       = ST_DONE;
          end
        end
        ST_DONE: begin
          if (consume_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (accept_s) begin
        a_d         = bus.a;
        sign_d      = bus.sign;
        bmsb_d      = bus.b[WIDTH-1];
        babs_d      = {1'b0, babs_in_s};
        dbz_d       = (bus.b == '0);
        rem_part_d  = '0;
        quot_part_d = aload_s;
        cnt_d       = cnt_load_s;
        state_d     = ST_CALC;
      end else begin
        state_d = state_d;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      a_q           <= '0;
      babs_q        <= '0;
      sign_q        <= 1'b0;
      bmsb_q        <= 1'b0;
      dbz_q         <= 1'b0;
      rem_part_q    <= '0;
      quot_part_q   <= '0;
      quot_q        <= '0;
      rem_q         <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      a_q           <= a_d;
      babs_q        <= babs_d;
      sign_q        <= sign_d;
      bmsb_q        <= bmsb_d;
      dbz_q         <= dbz_d;
      rem_part_q    <= rem_part_d;
      quot_part_q   <= quot_part_d;
      quot_q        <= quot_d;
      rem_q         <= rem_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter at WIDTH=32; latency expectations follow DIV_SKIP_LZ_EN.
module tb_div_iter;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  int err_cnt = 0;
  int chk_cnt = 0;
  exp_t sb_q[$];

  div_iter_if #(.WIDTH(W)) bus ();

  div_iter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    exp_t e;
    e.q = q;
    e.r = r;
    e.z = z;
    return e;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    e.z = 1'b0;
    if (b == 32'h0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
      e.z = 1'b1;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = a;
        e.r = 32'h0;
      end else begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] m;
    int lz;
    int it;
    m  = (s && a[W-1]) ? -a : a;
    lz = W;
    for (int i = W - 1; i >= 0; i--) begin
      if (m[i]) begin
        lz = W - 1 - i;
        break;
      end
    end
    it = (W - lz < 1) ? 1 : W - lz;
    if (b == 32'h0) return 1;
`ifdef DIV_SKIP_LZ_EN
    return it + 1;
`else
    return (it > 0) ? W + 1 : W + 1;
`endif
  endfunction

  // Pops and compares every result at the negedge before it is consumed
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("quot", bus.quot, e.q);
        check("rem", bus.rem, e.r);
        check("dbz", bus.div_by_zero, e.z);
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input exp_t e, input bit push, output int waits);
    bus.a        = a;
    bus.b        = b;
    bus.sign     = s;
    bus.in_valid = 1'b1;
    if (push) sb_q.push_back(e);
    #1;
    waits = 0;
    while (!bus.in_ready && waits < 100) begin
      @(posedge clk);
      #1;
      waits++;
    end
    if (waits >= 100) check("send_timeout", waits, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n, output bit ir_hi);
    n     = 0;
    ir_hi = 1'b0;
    while (!bus.out_valid && n < 200) begin
      if (bus.in_ready) ir_hi = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input exp_t e);
    int w;
    int n;
    bit ir;
    send(a, b, s, e, 1'b1, w);
    wait_valid(n, ir);
    check("latency", n, exp_lat(a, b, s));
    check("busy_in_ready", ir, 0);
    @(posedge clk);
    #1;
    check("consumed_ov", bus.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int n;
    bit ir;
    bit ov_seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rs;

    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sign      = 1'b0;
    bus.out_ready = 1'b1;
    #3;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_quot", bus.quot, 0);
    check("rst_rem", bus.rem, 0);
    check("rst_dbz", bus.div_by_zero, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("idle_in_ready", bus.in_ready, 1);

    run(32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2, 1'b0));
    run(32'hFFFF_FFF9, 32'd2, 1'b1, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0));
    run(32'd7, 32'hFFFF_FFFE, 1'b1, mk(32'hFFFF_FFFD, 32'd1, 1'b0));
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mk(32'h8000_0000, 32'h0, 1'b0));
    run(32'h1234, 32'h0, 1'b0, mk(32'hFFFF_FFFF, 32'h1234, 1'b1));
    run(32'd3, 32'd1, 1'b0, mk(32'd3, 32'd0, 1'b0));
    run(32'd0, 32'd5, 1'b0, mk(32'd0, 32'd0, 1'b0));
    run(32'hFFFF_FFFF, 32'd16, 1'b0, mk(32'h0FFF_FFFF, 32'd15, 1'b0));

    for (int k = 0; k < 6; k++) begin
      ra = $urandom;
      rb = (k % 2 == 0) ? W'($urandom_range(1, 1000)) : $urandom;
      if (rb == 32'h0) rb = 32'd3;
      rs = k[0] ^ k[1];
      run(ra, rb, rs, model(ra, rb, rs));
    end

    // Backpressure: result must hold while the consumer stalls
    bus.out_ready = 1'b0;
    send(32'd1000, 32'd7, 1'b0, mk(32'd142, 32'd6, 1'b0), 1'b1, w);
    wait_valid(n, ir);
    check("bp_latency", n, exp_lat(32'd1000, 32'd7, 1'b0));
    repeat (10) begin
      @(posedge clk);
      #1;
      check("bp_valid", bus.out_valid, 1);
      check("bp_quot", bus.quot, 32'd142);
      check("bp_rem", bus.rem, 32'd6);
    end

    // Back-to-back: consume and accept on the same edge
    bus.out_ready = 1'b1;
    send(32'd9, 32'd3, 1'b0, mk(32'd3, 32'd0, 1'b0), 1'b1, w);
    check("b2b_waits", w, 0);
    check("b2b_ov_after", bus.out_valid, 0);
    wait_valid(n, ir);
    check("b2b_latency", n, exp_lat(32'd9, 32'd3, 1'b0));
    @(posedge clk);
    #1;

    // Flush at iteration 5
    send(32'd77, 32'd4, 1'b0, mk(32'd0, 32'd0, 1'b0), 1'b0, w);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    bus.in_valid = 1'b1;
    #1 check("flush_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1 flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("flush_ov", bus.out_valid, 0);
    check("post_flush_in_ready", bus.in_ready, 1);
    ov_seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) ov_seen = 1'b1;
    end
    check("flush_no_result", ov_seen, 0);
    run(32'd50, 32'd5, 1'b0, mk(32'd10, 32'd0, 1'b0));

    // Asynchronous reset mid-CALC
    run(32'd1000, 32'd7, 1'b0, mk(32'd142, 32'd6, 1'b0));
    send(32'hFFFF_0000, 32'd3, 1'b0, mk(32'd0, 32'd0, 1'b0), 1'b0, w);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", bus.in_ready, 0);
    check("arst_ov", bus.out_valid, 0);
    check("arst_quot", bus.quot, 0);
    check("arst_rem", bus.rem, 0);
    check("arst_dbz", bus.div_by_zero, 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(32'd81, 32'd9, 1'b0, mk(32'd9, 32'd0, 1'b0));

    repeat (3) @(posedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
